pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning program-address width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning number of return-address entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_ADDR, default 0, meaning address loaded on reset and on clear.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port clear_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port clear  input  1  synchronous restart, active-high.
REQ-007 SHALL have port op  input  3  operation code, pc_op_t from the shared package.
REQ-008 SHALL have port target  input  ADDR_W  absolute address for JMP/CALL; two's-complement offset for BR.
REQ-009 SHALL have port address  output  ADDR_W  current instruction address, registered.
REQ-010 SHALL have port stack_empty  output  1  return stack holds zero entries.
REQ-011 SHALL have port stack_full  output  1  return stack holds STACK_DEPTH entries.
REQ-012 SHALL have port err  output  1  sticky flag: call overflow or return underflow occurred.

Function
REQ-013 Op encodings SHALL be: 0 NOP, 1 INC, 2 JMP, 3 BR, 4 CALL, 5 RET; 6 and 7 SHALL behave as NOP.
REQ-014 Every op SHALL take effect at the next rising clk edge; address reflects it one cycle after op is sampled.
REQ-015 NOP: address, stack and flags SHALL hold.
REQ-016 INC: address SHALL become address+1 modulo 2^ADDR_W (max value wraps to 0).
REQ-017 JMP: address SHALL become target.
REQ-018 BR: address SHALL become address+signed(target) modulo 2^ADDR_W; no overflow flag.
REQ-019 CALL, stack not full: SHALL push address+1 (wrapped) and set address to target in the same edge.
REQ-020 CALL, stack full: address SHALL advance by 1, no push, err SHALL set.
REQ-021 RET, stack not empty: address SHALL become the top entry, which is popped in the same edge.
REQ-022 RET, stack empty: address SHALL hold, err SHALL set.
REQ-023 clear=1 SHALL override op: address<=RESET_ADDR, stack emptied, err cleared.
REQ-024 stack_empty and stack_full SHALL be derived from a registered occupancy count of width clog2(STACK_DEPTH)+1.

Reset
REQ-025 clear_n low SHALL immediately force address=RESET_ADDR, occupancy 0, stack_empty=1, stack_full=0, err=0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight push/pop; stack entry contents need not be reset.
REQ-027 First op after clear_n deasserts SHALL be taken at the first subsequent rising edge.

Configuration
REQ-028 Macro PC_SEQ_STACK_EN defined: return stack, CALL/RET and stack flags SHALL operate as above.
REQ-029 Macro undefined: no stack storage; CALL SHALL act as JMP; RET SHALL act as NOP and set err; stack_empty tied 1, stack_full tied 0.

Structure
REQ-030 Package pc_seq_pkg SHALL hold the pc_op_t enum and the op encoding constants.
REQ-031 Return stack SHALL be sub-module pc_ret_stack (parameters ADDR_W, STACK_DEPTH; push, pop, din, dout, empty, full, clk, clear_n, clear), instantiated only under PC_SEQ_STACK_EN.

Verification (ADDR_W=7, STACK_DEPTH=4, RESET_ADDR=0, macro defined unless noted)
REQ-032 clear_n low mid-cycle at address=37 -> address=0 immediately, stack_empty=1, err=0.
REQ-033 address=126, INC x3 -> 127, 0, 1.
REQ-034 address=5, BR target=7'h7D (-3) -> 2; address=2, BR target=7'h7D -> 127.
REQ-035 address=10, CALL target=40, INC, RET -> 40, 41, 11; stack_empty=1 afterwards.
REQ-036 Five CALLs from empty -> stack_full=1 after fourth, fifth advances address by 1 and sets err; then clear=1 with op=RET -> address=0, err=0, stack_empty=1.
REQ-037 Macro undefined: address=10, CALL target=40 then RET -> 40, 40, err=1, stack_empty=1.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings and the pc_op_t enum.
package pc_seq_pkg;

    localparam logic [2:0] PC_OP_NOP  = 3'd0;
    localparam logic [2:0] PC_OP_INC  = 3'd1;
    localparam logic [2:0] PC_OP_JMP  = 3'd2;
    localparam logic [2:0] PC_OP_BR   = 3'd3;
    localparam logic [2:0] PC_OP_CALL = 3'd4;
    localparam logic [2:0] PC_OP_RET  = 3'd5;

    // Codes 6 and 7 are left unnamed and fall through to the NOP behaviour.
    typedef enum logic [2:0] {
        OP_NOP  = PC_OP_NOP,
        OP_INC  = PC_OP_INC,
        OP_JMP  = PC_OP_JMP,
        OP_BR   = PC_OP_BR,
        OP_CALL = PC_OP_CALL,
        OP_RET  = PC_OP_RET
    } pc_op_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Op/target command bus and status returned by the sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 7
);
    import pc_seq_pkg::*;

    // No handshake: the sequencer consumes op/target on every rising clk edge,
    // and address/flags are registered results valid for the whole following cycle.
    pc_op_t              op;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   address;
    logic                stack_empty;
    logic                stack_full;
    logic                err;

    modport master (
        output op, target,
        input  address, stack_empty, stack_full, err
    );

    modport slave (
        input  op, target,
        output address, stack_empty, stack_full, err
    );

endinterface

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses; occupancy counter is reset, entry storage is not.
module pc_ret_stack #(
    parameter int ADDR_W      = 7,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int             PTR_W   = $clog2(STACK_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(STACK_DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W+1)'(1);

    logic [PTR_W:0]    count_q, count_d;
    logic [PTR_W:0]    top_cnt;
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [ADDR_W-1:0] mem_d [STACK_DEPTH];

    assign top_cnt = count_q - ONE_C;
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign dout    = mem_q[top_cnt[PTR_W-1:0]];

    always_comb begin
        count_d = count_q;
        mem_d   = mem_q;
        if (clear) begin
            count_d = '0;
        end else if (push && !full) begin
            mem_d[count_q[PTR_W-1:0]] = din;
            count_d = count_q + ONE_C;
        end else if (pop && !empty) begin
            count_d = top_cnt;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) count_q <= '0;
        else          count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INC/JMP/BR plus CALL/RET through a return stack.
// Build with PC_SEQ_STACK_EN to include the stack; otherwise CALL jumps and RET only flags err.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = 7,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input logic           clk,
    input logic           clear_n,
    input logic           clear,
    pc_sequencer_if.slave bus
);

    if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pc_sequencer: STACK_DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] addr_inc;
    logic              err_q, err_d;

    assign addr_inc = addr_q + ADDR_W'(1);

`ifdef PC_SEQ_STACK_EN
    logic              stk_push, stk_pop, stk_empty, stk_full;
    logic [ADDR_W-1:0] stk_dout;

    // The return address pushed by CALL is the wrapped address+1.
    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (clk),
        .clear_n (clear_n),
        .clear   (clear),
        .push    (stk_push),
        .pop     (stk_pop),
        .din     (addr_inc),
        .dout    (stk_dout),
        .empty   (stk_empty),
        .full    (stk_full)
    );

    assign bus.stack_empty = stk_empty;
    assign bus.stack_full  = stk_full;
`else
    assign bus.stack_empty = 1'b1;
    assign bus.stack_full  = 1'b0;
`endif

    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
`ifdef PC_SEQ_STACK_EN
        stk_push = 1'b0;
        stk_pop  = 1'b0;
`endif
        if (clear) begin
            addr_d = RESET_ADDR;
            err_d  = 1'b0;
        end else begin
            case (bus.op)
                OP_INC:  addr_d = addr_inc;
                OP_JMP:  addr_d = bus.target;
                // Offset is two's complement, so a plain modular add handles both directions.
                OP_BR:   addr_d = addr_q + bus.target;
                OP_CALL: begin
`ifdef PC_SEQ_STACK_EN
                    if (stk_full) begin
                        addr_d = addr_inc;
                        err_d  = 1'b1;
                    end else begin
                        stk_push = 1'b1;
                        addr_d   = bus.target;
                    end
`else
                    addr_d = bus.target;
`endif
                end
                OP_RET: begin
`ifdef PC_SEQ_STACK_EN
                    if (stk_empty) begin
                        err_d = 1'b1;
                    end else begin
                        stk_pop = 1'b1;
                        addr_d  = stk_dout;
                    end
`else
                    err_d = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            addr_q <= RESET_ADDR;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    assign bus.address = addr_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; reference model tracks the stack as a plain queue.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int AW    = 7;
    localparam int DEPTH = 4;
`ifdef PC_SEQ_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clear_n;
    logic clear;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(AW)) bus ();

    pc_sequencer #(
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH),
        .RESET_ADDR  (7'd0)
    ) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .clear   (clear),
        .bus     (bus)
    );

    // ---------------- reference model / scoreboard ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          m_addr;
    logic        m_err;
    int          m_stack[$];
    logic [9:0]  exp_q[$];

    function automatic void model_reset();
        m_addr = 0;
        m_err  = 1'b0;
        m_stack.delete();
    endfunction

    function automatic void model_step(input int o, input int t, input bit clr);
        int off;
        if (clr) begin
            model_reset();
            return;
        end
        case (o)
            1: m_addr = (m_addr + 1) % 128;
            2: m_addr = t;
            3: begin
                off    = (t >= 64) ? t - 128 : t;
                m_addr = (m_addr + off + 128) % 128;
            end
            4: begin
                if (!STACK_EN) m_addr = t;
                else if (m_stack.size() < DEPTH) begin
                    m_stack.push_back((m_addr + 1) % 128);
                    m_addr = t;
                end else begin
                    m_addr = (m_addr + 1) % 128;
                    m_err  = 1'b1;
                end
            end
            5: begin
                if (STACK_EN && m_stack.size() > 0) m_addr = m_stack.pop_back();
                else m_err = 1'b1;
            end
            default: ;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic apply(input int o, input int t, input bit clr);
        logic [2:0] o3;
        logic [6:0] t7;
        o3 = 3'(o);
        t7 = 7'(t);
        bus.op     = pc_op_t'(o3);
        bus.target = t7;
        clear      = clr;
        @(posedge clk);
        #1;
        model_step(o, t, clr);
        exp_q.push_back({7'(m_addr), m_stack.size() == 0, m_stack.size() == DEPTH, m_err});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_n    = 1'b0;
        clear      = 1'b0;
        bus.op     = OP_NOP;
        bus.target = '0;
        #1;
        n_cmp++;
        if (bus.address !== 7'd0 || bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got addr=%0d empty=%b full=%b err=%b, expected addr=0 empty=1 full=0 err=0",
                     bus.address, bus.stack_empty, bus.stack_full, bus.err);
        end
        @(posedge clk);
        #2 clear_n = 1'b1;
        model_reset();
        apply(5, 0, 1'b0);   // RET on empty -> err set in both builds
        apply(4, 20, 1'b0);
        apply(2, 37, 1'b0);
        repeat (3) begin
            logic [9:0] exp;
            logic [9:0] got;
            exp = exp_q.pop_front();
            got = {bus.address, bus.stack_empty, bus.stack_full, bus.err};
        end
        n_cmp++;
        if (bus.address !== 7'd37 || bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got addr=%0d err=%b, expected addr=37 err=1", bus.address, bus.err);
        end
        // Pending CALL while reset hits mid-cycle must be discarded.
        bus.op     = OP_CALL;
        bus.target = 7'd50;
        #3 clear_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.address !== 7'd0 || bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%0d empty=%b full=%b err=%b, expected addr=0 empty=1 full=0 err=0",
                     bus.address, bus.stack_empty, bus.stack_full, bus.err);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.address !== 7'd0 || bus.stack_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: got addr=%0d empty=%b, expected addr=0 empty=1", bus.address, bus.stack_empty);
        end
        #1 clear_n = 1'b1;
        model_reset();
        apply(1, 0, 1'b0);
        begin
            logic [9:0] exp;
            logic [9:0] got;
            exp = exp_q.pop_front();
            got = {bus.address, bus.stack_empty, bus.stack_full, bus.err};
            n_cmp++;
            if (got !== exp || bus.address !== 7'd1) begin
                n_fail++;
                $display("FAIL first_op_after_reset: got addr=%0d empty=%b full=%b err=%b, expected addr=1 empty=%b full=%b err=%b",
                         got[9:3], got[2], got[1], got[0], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_inc_wrap();
        int ops[5]  = '{0, 2, 1, 1, 1};
        int tgs[5]  = '{0, 126, 0, 0, 0};
        int want[5] = '{0, 126, 127, 0, 1};
        for (int i = 0; i < 5; i++) begin
            logic [9:0] exp;
            logic [9:0] got;
            apply(ops[i], tgs[i], i == 0);
            exp = exp_q.pop_front();
            got = {bus.address, bus.stack_empty, bus.stack_full, bus.err};
            n_cmp++;
            if (got !== exp || int'(bus.address) != want[i]) begin
                n_fail++;
                $display("FAIL inc_wrap step %0d: got addr=%0d empty=%b full=%b err=%b, expected addr=%0d (model %0d) empty=%b full=%b err=%b",
                         i, got[9:3], got[2], got[1], got[0], want[i], exp[9:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_branch();
        int ops[4]  = '{0, 2, 3, 3};
        int tgs[4]  = '{0, 5, 'h7D, 'h7D};
        int want[4] = '{0, 5, 2, 127};
        for (int i = 0; i < 4; i++) begin
            logic [9:0] exp;
            logic [9:0] got;
            apply(ops[i], tgs[i], i == 0);
            exp = exp_q.pop_front();
            got = {bus.address, bus.stack_empty, bus.stack_full, bus.err};
            n_cmp++;
            if (got !== exp || int'(bus.address) != want[i]) begin
                n_fail++;
                $display("FAIL branch step %0d: got addr=%0d err=%b, expected addr=%0d (model %0d) err=%b",
                         i, got[9:3], got[0], want[i], exp[9:3], exp[0]);
            end
        end
    endtask

    task automatic test_call_ret();
        // clear, JMP 10, CALL 40, INC, RET, then clear, JMP 10, CALL 40, RET
        int ops[9]  = '{0, 2, 4, 1, 5, 0, 2, 4, 5};
        int tgs[9]  = '{0, 10, 40, 0, 0, 0, 10, 40, 0};
        bit clr[9]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
        int want[9];
        want = '{0, 10, 40, 41, STACK_EN ? 11 : 41, 0, 10, 40, STACK_EN ? 11 : 40};
        for (int i = 0; i < 9; i++) begin
            logic [9:0] exp;
            logic [9:0] got;
            apply(ops[i], tgs[i], clr[i]);
            exp = exp_q.pop_front();
            got = {bus.address, bus.stack_empty, bus.stack_full, bus.err};
            n_cmp++;
            if (got !== exp || int'(bus.address) != want[i]) begin
                n_fail++;
                $display("FAIL call_ret step %0d: got addr=%0d empty=%b full=%b err=%b, expected addr=%0d (model %0d) empty=%b full=%b err=%b",
                         i, got[9:3], got[2], got[1], got[0], want[i], exp[9:3], exp[2], exp[1], exp[0]);
            end
        end
        n_cmp++;
        if (bus.stack_empty !== 1'b1 || bus.err !== !STACK_EN) begin
            n_fail++;
            $display("FAIL call_ret_final: got empty=%b err=%b, expected empty=1 err=%b", bus.stack_empty, bus.err, !STACK_EN);
        end
    endtask

    task automatic test_overflow();
        int ops[7] = '{0, 4, 4, 4, 4, 4, 5};
        int tgs[7] = '{0, 20, 30, 40, 50, 60, 0};
        bit clr[7] = '{1, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            logic [9:0] exp;
            logic [9:0] got;
            apply(ops[i], tgs[i], clr[i]);
            exp = exp_q.pop_front();
            got = {bus.address, bus.stack_empty, bus.stack_full, bus.err};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL overflow step %0d: got addr=%0d empty=%b full=%b err=%b, expected addr=%0d empty=%b full=%b err=%b",
                         i, got[9:3], got[2], got[1], got[0], exp[9:3], exp[2], exp[1], exp[0]);
            end
            if (i == 5) begin
                n_cmp++;
                if (bus.stack_full !== STACK_EN || bus.err !== STACK_EN || bus.address !== (STACK_EN ? 7'd51 : 7'd60)) begin
                    n_fail++;
                    $display("FAIL overflow_fifth_call: got addr=%0d full=%b err=%b, expected addr=%0d full=%b err=%b",
                             bus.address, bus.stack_full, bus.err, STACK_EN ? 51 : 60, STACK_EN, STACK_EN);
                end
            end
        end
        n_cmp++;
        if (bus.address !== 7'd0 || bus.err !== 1'b0 || bus.stack_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_overrides_ret: got addr=%0d err=%b empty=%b, expected addr=0 err=0 empty=1",
                     bus.address, bus.err, bus.stack_empty);
        end
    endtask

    task automatic test_random();
        apply(0, 0, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 400; i++) begin
            int         o;
            int         t;
            bit         clr;
            logic [9:0] exp;
            logic [9:0] got;
            o   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 7));
            t   = $urandom_range(0, 127);
            clr = ($urandom_range(0, 31) == 0);
            apply(o, t, clr);
            exp = exp_q.pop_front();
            got = {bus.address, bus.stack_empty, bus.stack_full, bus.err};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random step %0d op=%0d tgt=%0d clr=%0b: got addr=%0d empty=%b full=%b err=%b, expected addr=%0d empty=%b full=%b err=%b",
                         i, o, t, clr, got[9:3], got[2], got[1], got[0], exp[9:3], exp[2], exp[1], exp[0]);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_inc_wrap();
        test_branch();
        test_call_ret();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
